// File: rtl/ex_muldiv_unit_pkg.sv
// rtl/ex_muldiv_unit_pkg.sv - op codes, FSM states and op decode helpers for the mul/div unit
package ex_muldiv_unit_pkg;

   localparam int MULDIV_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } state_e;

   // Divide ops share the upper op bit; the mode is chosen once at accept.
   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Signed ops take operand magnitudes and get their signs restored in FIX.
   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_step.sv
// rtl/ex_muldiv_unit_step.sv - one combinational shift-add / restoring shift-subtract iteration
module ex_muldiv_unit_step
   import ex_muldiv_unit_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic             mode_div,
   input  logic [WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] acc_out,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             ge;

   // MUL: {acc,q} holds the partial product over the remaining multiplier bits.
   // DIV: acc is the partial remainder, q shifts the dividend out and quotient bits in.
   always_comb begin
      sum     = {1'b0, acc_in} + (q_in[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
      shifted = {acc_in, q_in[WIDTH-1]};
      ge      = (shifted >= {1'b0, m});
      // When ge holds the true difference is below m, so the WIDTH-bit wrap is exact.
      diff    = shifted[WIDTH-1:0] - m;
      if (mode_div) begin
         acc_out = ge ? diff : shifted[WIDTH-1:0];
         q_out   = {q_in[WIDTH-2:0], ge};
      end else begin
         acc_out = sum[WIDTH:1];
         q_out   = {sum[0], q_in[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - EX-stage iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] mt_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam int PW = 2 * WIDTH;

   state_e           state;
   state_e           state_nxt;
   logic [CW-1:0]    cnt;
   logic             last_iter;
   logic             accept;

   logic             op_div;
   logic             neg_a;
   logic             neg_b;
   logic             div0;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] rs_raw;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] q_nxt;

   logic             signed_op;
   logic [WIDTH-1:0] rs_mag;
   logic [WIDTH-1:0] rt_mag;
   logic [PW-1:0]    prod_fix;
   logic [WIDTH-1:0] quot_fix;
   logic [WIDTH-1:0] rem_fix;

   assign last_iter = (cnt == CW'(WIDTH - 1));

   ex_muldiv_unit_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .mode_div (op_div),
      .acc_in   (acc),
      .q_in     (q),
      .m        (m),
      .acc_out  (acc_nxt),
      .q_out    (q_nxt)
   );

   // Operand magnitudes at accept; 0x80000000 negates to itself and reads as unsigned 2^31.
   always_comb begin
      signed_op = op_is_signed(op);
      rs_mag    = (signed_op && rs_val[WIDTH-1]) ? (~rs_val + WIDTH'(1)) : rs_val;
      rt_mag    = (signed_op && rt_val[WIDTH-1]) ? (~rt_val + WIDTH'(1)) : rt_val;
   end

   // Sign restoration applied to the finished magnitudes in FIX.
   always_comb begin
      prod_fix = (neg_a ^ neg_b) ? (~{acc, q} + PW'(1)) : {acc, q};
      quot_fix = (neg_a ^ neg_b) ? (~q + WIDTH'(1)) : q;
      rem_fix  = neg_a ? (~acc + WIDTH'(1)) : acc;
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, accept strobe and busy.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last_iter) begin
               state_nxt = FIX;
            end
         end
         FIX: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: MTHI/MTLO in IDLE, operand latch at accept, iterations in RUN, result write in FIX.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         cnt         <= '0;
         op_div      <= 1'b0;
         neg_a       <= 1'b0;
         neg_b       <= 1'b0;
         div0        <= 1'b0;
         acc         <= '0;
         q           <= '0;
         m           <= '0;
         rs_raw      <= '0;
      end else begin
         done <= 1'b0;

         if (state == IDLE) begin
            if (hi_we) begin
               hi <= mt_data;
            end
            if (lo_we) begin
               lo <= mt_data;
            end
         end

         if (accept) begin
            op_div      <= op_is_div(op);
            neg_a       <= signed_op & rs_val[WIDTH-1];
            neg_b       <= signed_op & rt_val[WIDTH-1];
            div0        <= op_is_div(op) && (rt_val == '0);
            rs_raw      <= rs_val;
            acc         <= '0;
            q           <= rs_mag;
            m           <= rt_mag;
            cnt         <= '0;
            div_by_zero <= 1'b0;
         end

         if (state == RUN) begin
            acc <= acc_nxt;
            q   <= q_nxt;
            cnt <= cnt + CW'(1);
         end

         if (state == FIX) begin
            done <= 1'b1;
            if (!op_div) begin
               hi <= prod_fix[PW-1:WIDTH];
               lo <= prod_fix[WIDTH-1:0];
            end else if (div0) begin
               hi          <= rs_raw;
               lo          <= '1;
               div_by_zero <= 1'b1;
            end else begin
               hi <= rem_fix;
               lo <= quot_fix;
            end
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed and randomized self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] mt_data;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   int          vectors = 0;
   int          miscompares = 0;
   int unsigned cyc = 0;
   int unsigned t0 = 0;
   logic [31:0] exp_hi;
   logic [31:0] exp_lo;
   logic        exp_dz;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   ex_muldiv_unit dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .mt_data     (mt_data),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference results from plain 64-bit integer arithmetic.
   function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output logic dz);
      longint      sa;
      longint      sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      h  = '0;
      l  = '0;
      dz = 1'b0;
      case (o)
         2'b00: begin
            p = sa * sb;
            h = p[63:32];
            l = p[31:0];
         end
         2'b01: begin
            p = {32'b0, a} * {32'b0, b};
            h = p[63:32];
            l = p[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               h  = a;
               l  = 32'hFFFF_FFFF;
               dz = 1'b1;
            end else if (o == 2'b10) begin
               p = sa / sb;
               l = p[31:0];
               p = sa % sb;
               h = p[31:0];
            end else begin
               l = a / b;
               h = a % b;
            end
         end
      endcase
   endfunction

   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op     = o;
      rs_val = a;
      rt_val = b;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      t0     = cyc;
      rs_val = $urandom;
      rt_val = $urandom;
      check("busy_after_accept", {63'b0, busy}, 64'd1);
      check("dz_cleared_at_accept", {63'b0, div_by_zero}, 64'd0);
   endtask

   task automatic finish(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      model(o, a, b, exp_hi, exp_lo, exp_dz);
      while (!done && (cyc - t0) < 100) @(negedge clk);
      check({tag, ":latency"}, 64'(cyc - t0), 64'd33);
      check({tag, ":busy_in_done"}, {63'b0, busy}, 64'd0);
      check({tag, ":hi"}, {32'b0, hi}, {32'b0, exp_hi});
      check({tag, ":lo"}, {32'b0, lo}, {32'b0, exp_lo});
      check({tag, ":dz"}, {63'b0, div_by_zero}, {63'b0, exp_dz});
      @(negedge clk);
      check({tag, ":done_one_cycle"}, {63'b0, done}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      int          sel;
      logic        saw_done;

      rst     = 1'b1;
      start   = 1'b0;
      hi_we   = 1'b0;
      lo_we   = 1'b0;
      op      = 2'b00;
      rs_val  = '0;
      rt_val  = '0;
      mt_data = '0;
      repeat (3) @(negedge clk);
      check("reset_hi", {32'b0, hi}, 64'd0);
      check("reset_lo", {32'b0, lo}, 64'd0);
      check("reset_busy", {63'b0, busy}, 64'd0);
      check("reset_done", {63'b0, done}, 64'd0);
      check("reset_dz", {63'b0, div_by_zero}, 64'd0);
      rst = 1'b0;

      // MTHI / MTLO while idle
      @(negedge clk);
      hi_we   = 1'b1;
      mt_data = 32'hA5A5_0001;
      @(negedge clk);
      hi_we   = 1'b0;
      check("mthi_idle", {32'b0, hi}, 64'hA5A5_0001);
      lo_we   = 1'b1;
      mt_data = 32'h5A5A_0002;
      @(negedge clk);
      lo_we   = 1'b0;
      check("mtlo_idle", {32'b0, lo}, 64'h5A5A_0002);

      // MULTU max x max
      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      finish("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu_max_hi_const", {32'b0, hi}, 64'hFFFF_FFFE);
      check("multu_max_lo_const", {32'b0, lo}, 64'h0000_0001);

      // MULT -3 x 7
      launch(2'b00, 32'hFFFF_FFFD, 32'd7);
      finish("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7);
      check("mult_neg_lo_const", {32'b0, lo}, 64'hFFFF_FFEB);

      // DIV -7 / 2 and DIVU 7 / 2
      launch(2'b10, 32'hFFFF_FFF9, 32'd2);
      finish("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
      check("div_neg_lo_const", {32'b0, lo}, 64'hFFFF_FFFD);
      check("div_neg_hi_const", {32'b0, hi}, 64'hFFFF_FFFF);
      launch(2'b11, 32'd7, 32'd2);
      finish("divu_7_2", 2'b11, 32'd7, 32'd2);
      check("divu_lo_const", {32'b0, lo}, 64'd3);
      check("divu_hi_const", {32'b0, hi}, 64'd1);

      // Divide by zero, flag cleared by the next accepted start
      launch(2'b11, 32'd100, 32'd0);
      finish("divu_zero", 2'b11, 32'd100, 32'd0);
      check("divu_zero_flag_const", {63'b0, div_by_zero}, 64'd1);
      launch(2'b11, 32'd9, 32'd3);
      finish("after_div0", 2'b11, 32'd9, 32'd3);

      // Signed overflow case
      launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      finish("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      check("div_ovf_lo_const", {32'b0, lo}, 64'h8000_0000);

      // MTHI/MTLO together with an accepted start: visible at E0, overwritten at FIX
      @(negedge clk);
      op      = 2'b01;
      rs_val  = 32'd5;
      rt_val  = 32'd6;
      start   = 1'b1;
      hi_we   = 1'b1;
      lo_we   = 1'b1;
      mt_data = 32'h0000_DEAD;
      @(negedge clk);
      start   = 1'b0;
      hi_we   = 1'b0;
      lo_we   = 1'b0;
      t0      = cyc;
      check("mt_with_start_hi", {32'b0, hi}, 64'h0000_DEAD);
      check("mt_with_start_lo", {32'b0, lo}, 64'h0000_DEAD);
      finish("mt_with_start", 2'b01, 32'd5, 32'd6);

      // start and MTLO during busy are ignored
      launch(2'b11, 32'd7, 32'd2);
      repeat (4) @(negedge clk);
      op      = 2'b01;
      rs_val  = 32'd3;
      rt_val  = 32'd3;
      start   = 1'b1;
      lo_we   = 1'b1;
      mt_data = 32'h0000_1234;
      @(negedge clk);
      start   = 1'b0;
      lo_we   = 1'b0;
      check("busy_mtlo_ignored", {32'b0, lo}, {32'b0, exp_lo});
      finish("busy_start_ignored", 2'b11, 32'd7, 32'd2);
      repeat (3) @(negedge clk);
      check("no_queued_start", {63'b0, busy}, 64'd0);

      // Reset at iteration 10 of a MULT
      launch(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", {63'b0, busy}, 64'd0);
      check("midrst_hi", {32'b0, hi}, 64'd0);
      check("midrst_lo", {32'b0, lo}, 64'd0);
      check("midrst_done", {63'b0, done}, 64'd0);
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("midrst_no_done", {63'b0, saw_done}, 64'd0);

      // Randomized operations with boundary operand bias
      for (int i = 0; i < 40; i++) begin
         ro  = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         sel = $urandom_range(0, 7);
         case (sel)
            0: rb = 32'd0;
            1: ra = 32'h8000_0000;
            2: rb = 32'hFFFF_FFFF;
            3: rb = 32'($urandom_range(1, 15));
            4: ra = 32'($urandom_range(0, 1000));
            default: ;
         endcase
         launch(ro, ra, rb);
         finish($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
